// File: rtl/tx_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tx_arbiter
// Shares one TxUnit between N_REQ requesters. Requests are served round-robin starting after
// the last requester that owned the TxUnit. Each granted frame is launched with tx_start, then
// the arbiter waits for tx_done, or abandons the frame after TIMEOUT_CYCLES cycles. Every output
// comes straight from a flop.
//
// Ports
//   system_clk   in   single clock, rising edge
//   reset        in   asynchronous, active-high
//   req_valid    in   [N_REQ]     per-requester frame request (held until req_ack)
//   req_data     in   [8*N_REQ]   requester i byte at [8i+7:8i]
//   req_parity   in   [2*N_REQ]   requester i parity mode at [2i+1:2i]
//   req_baud     in   [2*N_REQ]   requester i baud config at [2i+1:2i]
//   req_ack      out  [N_REQ]     one-cycle pulse: request accepted, data latched
//   req_done     out  [N_REQ]     one-cycle pulse: frame completed normally
//   tx_start     out              TxUnit start_send
//   tx_data      out  [8]         TxUnit input_data
//   tx_parity    out  [2]         TxUnit parity_mode
//   tx_baud      out  [2]         TxUnit baud_config
//   tx_busy      in               TxUnit is_transmitting
//   tx_done      in               TxUnit transmission_done
//   grant_id     out  [3]         requester currently owning the TxUnit
//   busy         out              high whenever the arbiter is not idle
//   timeout_err  out              one-cycle pulse when a frame is abandoned
// ---------------------------------------------------------------------------------------------
module tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                 system_clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [2*N_REQ-1:0]   req_parity,
    input  logic [2*N_REQ-1:0]   req_baud,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     req_done,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic [1:0]           tx_parity,
    output logic [1:0]           tx_baud,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitDone,
        StRelease
    } state_e;

    localparam logic [23:0] TimeoutLast = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LastInit    = 3'(N_REQ - 1);

    state_e             r_state, w_state_next;
    logic [2:0]         r_last_grant, w_last_grant_next;
    logic [23:0]        r_cnt, w_cnt_next;
    logic [N_REQ-1:0]   r_req_ack, w_req_ack_next;
    logic [N_REQ-1:0]   r_req_done, w_req_done_next;
    logic               r_tx_start, w_tx_start_next;
    logic [7:0]         r_tx_data, w_tx_data_next;
    logic [1:0]         r_tx_parity, w_tx_parity_next;
    logic [1:0]         r_tx_baud, w_tx_baud_next;
    logic [2:0]         r_grant_id, w_grant_id_next;
    logic               r_busy, w_busy_next;
    logic               r_timeout_err, w_timeout_err_next;

    // Round-robin pick
    logic               w_found_hi, w_found_lo;
    logic [2:0]         w_sel_hi, w_sel_lo, w_sel;
    logic [N_REQ-1:0]   w_sel_onehot, w_grant_onehot;
    logic [7:0]         w_sel_data;
    logic [1:0]         w_sel_parity, w_sel_baud;
    logic               w_timeout_hit;

    // Lowest valid index above last_grant wins; if there is none, wrap to the lowest valid index.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_sel_hi   = 3'd0;
        w_sel_lo   = 3'd0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !w_found_lo) begin
                w_found_lo = 1'b1;
                w_sel_lo   = 3'(i);
            end
            if (req_valid[i] && (3'(i) > r_last_grant) && !w_found_hi) begin
                w_found_hi = 1'b1;
                w_sel_hi   = 3'(i);
            end
        end
        w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
    end

    always_comb begin
        w_sel_onehot   = '0;
        w_grant_onehot = '0;
        w_sel_data     = 8'd0;
        w_sel_parity   = 2'd0;
        w_sel_baud     = 2'd0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_sel_onehot[i]   = (3'(i) == w_sel);
            w_grant_onehot[i] = (3'(i) == r_grant_id);
            if (3'(i) == w_sel) begin
                w_sel_data   = req_data[8*i +: 8];
                w_sel_parity = req_parity[2*i +: 2];
                w_sel_baud   = req_baud[2*i +: 2];
            end
        end
    end

    assign w_timeout_hit = (r_cnt == TimeoutLast);

    // Next-state and registered-output logic
    always_comb begin
        w_state_next       = r_state;
        w_last_grant_next  = r_last_grant;
        w_cnt_next         = r_cnt;
        w_req_ack_next     = '0;
        w_req_done_next    = '0;
        w_tx_start_next    = 1'b0;
        w_tx_data_next     = r_tx_data;
        w_tx_parity_next   = r_tx_parity;
        w_tx_baud_next     = r_tx_baud;
        w_grant_id_next    = r_grant_id;
        w_timeout_err_next = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_found_lo) begin
                    w_state_next     = StStart;
                    w_req_ack_next   = w_sel_onehot;
                    w_tx_start_next  = 1'b1;
                    w_tx_data_next   = w_sel_data;
                    w_tx_parity_next = w_sel_parity;
                    w_tx_baud_next   = w_sel_baud;
                    w_grant_id_next  = w_sel;
                    w_cnt_next       = 24'd0;
                end
            end
            StStart: begin
                w_cnt_next = r_cnt + 24'd1;
                if (w_timeout_hit) begin
                    w_timeout_err_next = 1'b1;
                    w_last_grant_next  = r_grant_id;
                    w_state_next       = StRelease;
                end else if (tx_busy) begin
                    w_state_next = StWaitDone;
                end else begin
                    w_tx_start_next = 1'b1;
                end
            end
            StWaitDone: begin
                w_cnt_next = r_cnt + 24'd1;
                // A done arriving on the last counted cycle still counts as a normal completion.
                if (tx_done) begin
                    w_req_done_next   = w_grant_onehot;
                    w_last_grant_next = r_grant_id;
                    w_state_next      = StRelease;
                end else if (w_timeout_hit) begin
                    w_timeout_err_next = 1'b1;
                    w_last_grant_next  = r_grant_id;
                    w_state_next       = StRelease;
                end
            end
            StRelease: begin
                if (!tx_busy && !tx_done) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        w_busy_next = (w_state_next != StIdle);
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_last_grant  <= LastInit;
            r_cnt         <= 24'd0;
            r_req_ack     <= '0;
            r_req_done    <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'd0;
            r_tx_parity   <= 2'd0;
            r_tx_baud     <= 2'd0;
            r_grant_id    <= 3'd0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_last_grant  <= w_last_grant_next;
            r_cnt         <= w_cnt_next;
            r_req_ack     <= w_req_ack_next;
            r_req_done    <= w_req_done_next;
            r_tx_start    <= w_tx_start_next;
            r_tx_data     <= w_tx_data_next;
            r_tx_parity   <= w_tx_parity_next;
            r_tx_baud     <= w_tx_baud_next;
            r_grant_id    <= w_grant_id_next;
            r_busy        <= w_busy_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    assign req_ack     = r_req_ack;
    assign req_done    = r_req_done;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign tx_parity   = r_tx_parity;
    assign tx_baud     = r_tx_baud;
    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one TxUnit (legal 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 200000, maximum number of system_clk cycles from a frame start to tx_done before the frame is abandoned (legal 16..2^24-1).
REQ-003 system_clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  N_REQ  per-requester frame request; held high until req_ack.
REQ-006 req_data  in  8*N_REQ  requester i byte at bits [8i+7:8i].
REQ-007 req_parity  in  2*N_REQ  requester i parity mode at bits [2i+1:2i] (TxUnit encoding).
REQ-008 req_baud  in  2*N_REQ  requester i baud config at bits [2i+1:2i] (TxUnit encoding).
REQ-009 req_ack  out  N_REQ  one-cycle pulse: request i accepted, its data latched.
REQ-010 req_done  out  N_REQ  one-cycle pulse: requester i frame completed normally.
REQ-011 tx_start  out  1  drives TxUnit start_send.
REQ-012 tx_data / tx_parity / tx_baud  out  8 / 2 / 2  drive TxUnit input_data / parity_mode / baud_config.
REQ-013 tx_busy  in  1  TxUnit is_transmitting.
REQ-014 tx_done  in  1  TxUnit transmission_done.
REQ-015 grant_id  out  3  index of the requester currently owning the TxUnit.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 timeout_err  out  1  one-cycle pulse when a frame is abandoned on timeout.

Function
REQ-018 States: IDLE, START, WAIT_DONE, RELEASE; all outputs registered.
REQ-019 IDLE: when any req_valid is high, select the first valid requester scanning round-robin from last_grant+1 (mod N_REQ) upward, and go to START.
REQ-020 On that IDLE->START edge: latch the selected req_data/req_parity/req_baud into tx_data/tx_parity/tx_baud, set grant_id, and pulse req_ack[grant] for exactly one cycle.
REQ-021 Latency: req_valid sampled high in IDLE at edge t -> req_ack, tx_start and the new tx_data are visible in the cycle following edge t.
REQ-022 START: tx_start=1; when tx_busy=1 is sampled, go to WAIT_DONE with tx_start=0 from the next cycle.
REQ-023 WAIT_DONE: when tx_done=1 is sampled, pulse req_done[grant_id] for one cycle, set last_grant=grant_id, and go to RELEASE.
REQ-024 RELEASE: tx_start=0; go to IDLE when tx_busy=0 and tx_done=0 are sampled in the same cycle; no new grant is issued from RELEASE.
REQ-025 tx_data, tx_parity, tx_baud and grant_id stay constant from START through RELEASE; input changes on any requester are ignored until the next IDLE grant.
REQ-026 A 24-bit timeout counter clears on entry to START and increments every cycle in START and WAIT_DONE.
REQ-027 When the counter reaches TIMEOUT_CYCLES-1 without tx_done: pulse timeout_err, drive tx_start=0, set last_grant=grant_id, go to RELEASE, and issue no req_done.
REQ-028 If tx_done and the timeout condition occur in the same cycle, tx_done wins (req_done, no timeout_err).
REQ-029 A requester that drops req_valid before ack is not granted; req_valid for the granted requester after ack is treated as a new request in a later IDLE cycle.
REQ-030 At most one bit of req_ack and of req_done is high in any cycle.

Reset
REQ-031 While reset=1: state=IDLE, last_grant=N_REQ-1 (requester 0 has first priority), counter=0, and req_ack, req_done, tx_start, tx_data, tx_parity, tx_baud, grant_id, busy and timeout_err are all 0.
REQ-032 Reset asserted mid-frame returns to IDLE immediately with tx_start=0 and no req_done or timeout_err pulse.

Verification
REQ-033 Single request: after reset, req_valid=0001 with data 0xAA, parity 01, baud 00 -> next cycle req_ack=0001, tx_start=1, tx_data=0xAA; tx_busy -> tx_start=0; tx_done -> req_done=0001; back to IDLE.
REQ-034 Round-robin: req_valid=1111 held, each request re-asserted after its ack -> grants in order 0,1,2,3,0, one frame each.
REQ-035 Simultaneous done and timeout: TIMEOUT_CYCLES=16 with tx_done asserted on the 16th counted cycle -> req_done pulses and timeout_err stays 0.
REQ-036 Timeout: TIMEOUT_CYCLES=16 with tx_busy=1 and tx_done never asserted -> timeout_err pulse 16 cycles after START, no req_done, next grant goes to the following requester.
REQ-037 Reset mid-frame: reset pulsed in WAIT_DONE -> all outputs 0 asynchronously; a subsequent req_valid=0100 is granted requester 2 normally.
REQ-038 Stability: all req_data inputs toggle every cycle during WAIT_DONE -> tx_data holds the latched byte until RELEASE exits.
